// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// The sequencer FSM encoding and the per-cycle pipeline control word live here.
package pipeline_hazard_ctrl_pkg;

  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_DMEM_WAIT = 1'b1
  } state_e;

  // Write enables for PC and the four pipeline registers, then the three flushes.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = ctrl_t'(8'b11111_000);
  localparam ctrl_t CTRL_HOLD   = ctrl_t'(8'b00000_000);
  // Load-use bubble: hold PC and IF/ID, inject a bubble into ID/EX.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(8'b00111_010);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(8'b11111_111);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// dmem_req/dmem_ready: an access completes on any cycle where both are high;
// once raised, dmem_req stays high until that cycle or until the wait times out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = pipeline_hazard_ctrl_pkg::DEF_CNT_W
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic [4:0]       rd_EX;
  logic             memread_EX;
  logic             memread_MEM;
  logic             memwrite_MEM;
  logic             branch_taken_MEM;
  logic             dmem_ready;

  logic             dmem_req;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  state_e           dbg_state;

  modport master (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, memread_EX,
           memread_MEM, memwrite_MEM, branch_taken_MEM, dmem_ready,
    input  dmem_req, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, mem_err, stall_cnt, flush_cnt,
           dbg_state
  );

  modport slave (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, memread_EX,
           memread_MEM, memwrite_MEM, branch_taken_MEM, dmem_ready,
    output dmem_req, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, mem_err, stall_cnt, flush_cnt,
           dbg_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use check: does the ID instruction read the register
// that the load currently in EX will write? x0 never creates a hazard.
module load_use_detect (
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       memread_ex,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = use_rs1_id && (rs1_id == rd_ex);
  assign rs2_match = use_rs2_id && (rs2_id == rd_ex);
  assign hazard    = memread_ex && (rd_ex != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: DMEM wait with timeout,
// taken-branch flush, load-use bubble, and saturating event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              mem_err_q;

  logic  hazard;
  logic  memop;
  logic  timed_out;
  logic  dmem_req;
  ctrl_t ctrl;
  logic  stall_evt;
  logic  flush_evt;
  logic  err_evt;

  load_use_detect u_load_use_detect (
    .rs1_id     (bus.rs1_ID),
    .rs2_id     (bus.rs2_ID),
    .use_rs1_id (bus.use_rs1_ID),
    .use_rs2_id (bus.use_rs2_ID),
    .rd_ex      (bus.rd_EX),
    .memread_ex (bus.memread_EX),
    .hazard     (hazard)
  );

  assign memop     = bus.memread_MEM || bus.memwrite_MEM;
  assign timed_out = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_NORMAL;
    dmem_req   = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    err_evt    = 1'b0;
    if (rst) begin
      ctrl       = CTRL_HOLD;
      state_d    = ST_RUN;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          dmem_req = memop;
          if (memop && !bus.dmem_ready) begin
            ctrl       = CTRL_HOLD;
            stall_evt  = 1'b1;
            state_d    = ST_DMEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (bus.branch_taken_MEM) begin
            ctrl      = CTRL_FLUSH;
            flush_evt = 1'b1;
          end else if (hazard) begin
            ctrl      = CTRL_BUBBLE;
            stall_evt = 1'b1;
          end
        end
        ST_DMEM_WAIT: begin
          dmem_req = 1'b1;
          // Timeout is treated as a completion so the pipeline never deadlocks.
          if (bus.dmem_ready || timed_out) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            err_evt    = !bus.dmem_ready;
            if (bus.branch_taken_MEM) begin
              ctrl      = CTRL_FLUSH;
              flush_evt = 1'b1;
            end
          end else begin
            ctrl       = CTRL_HOLD;
            stall_evt  = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (err_evt) mem_err_q <= 1'b1;
    end
  end

  assign bus.dmem_req    = dmem_req;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ifid_write  = ctrl.ifid_write;
  assign bus.idex_write  = ctrl.idex_write;
  assign bus.exmem_write = ctrl.exmem_write;
  assign bus.memwb_write = ctrl.memwb_write;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.dbg_state   = state_q;

endmodule
